hazard_controller: RTL and testbench



---
 rtl/riscv_pkg.sv | 25 ++
 rtl/hazard_controller_sat_counter.sv | 27 ++
 rtl/hazard_controller.sv | 146 ++++++++++++++
 tb/tb_hazard_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the 5-stage core's pipeline control logic.
//   REG_ADDR_W : width of a register-file address
//   hz_state_t : hazard controller FSM state
//   ctrl_t     : ID/EX control fields that a bubble forces to zero
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } hz_state_t;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg_write;
   } ctrl_t;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   in  1  clock, rising edge
//   rstN  in  1  asynchronous active-low reset, clears count
//   inc   in  1  add one on this edge (ignored once saturated)
//   count out W  current count
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rstN,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
// Hazard and stall sequencing for the ID/EX boundary of the 5-stage core:
// load-use stalls, taken-branch flushes, whole-pipeline freeze while data
// memory is busy, a sticky memory timeout, and saturating stall/flush counts.
// Ports:
//   clk            in  1      core clock, rising edge
//   rstN           in  1      asynchronous active-low reset
//   rs1_ID/rs2_ID  in  5      source registers of the ID instruction
//   usesRs1_ID/2   in  1      ID instruction actually reads rs1/rs2
//   rd_EX          in  5      destination of the EX instruction
//   memRead_EX     in  1      EX instruction is a load
//   branchTaken_EX in  1      EX resolved a taken branch/jump
//   memReq_MEM     in  1      MEM stage is accessing data memory
//   memReady_MEM   in  1      data memory completes this cycle
//   stall_IF       out 1      hold PC and IF/ID
//   bubble_ID_EX   out 1      zero the ID/EX control fields
//   flush_IF_ID    out 1      invalidate IF/ID
//   freeze         out 1      hold every pipeline register and PC
//   memTimeout     out 1      sticky memory-hang error
//   stallCount     out CNT_W  load-use plus freeze cycles, saturating
//   flushCount     out CNT_W  taken-branch flushes, saturating
// ---------------------------------------------------------------------------
module hazard_controller
   import riscv_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic [REG_ADDR_W-1:0] rs1_ID,
   input  logic [REG_ADDR_W-1:0] rs2_ID,
   input  logic                  usesRs1_ID,
   input  logic                  usesRs2_ID,
   input  logic [REG_ADDR_W-1:0] rd_EX,
   input  logic                  memRead_EX,
   input  logic                  branchTaken_EX,
   input  logic                  memReq_MEM,
   input  logic                  memReady_MEM,
   output logic                  stall_IF,
   output logic                  bubble_ID_EX,
   output logic                  flush_IF_ID,
   output logic                  freeze,
   output logic                  memTimeout,
   output logic [CNT_W-1:0]      stallCount,
   output logic [CNT_W-1:0]      flushCount
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   hz_state_t         state;
   hz_state_t         next_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              rs1_hit;
   logic              rs2_hit;
   logic              load_use;
   logic              mem_wait;
   logic              stall_inc;

   // x0 is never a real producer, so a load targeting it cannot cause a hazard.
   assign rs1_hit  = usesRs1_ID && (rs1_ID == rd_EX);
   assign rs2_hit  = usesRs2_ID && (rs2_ID == rd_EX);
   assign load_use = memRead_EX && (rd_EX != '0) && (rs1_hit || rs2_hit);

   // A ready pulse with no request in flight carries no meaning.
   assign mem_wait = memReq_MEM && !memReady_MEM;

   // State register
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // Wait counter: held at zero in RUN, so the first MEM_WAIT cycle sees 0.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wait_cnt <= '0;
      end else if (state == RUN) begin
         wait_cnt <= '0;
      end else if (state == MEM_WAIT) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      unique case (state)
         RUN: begin
            if (mem_wait) next_state = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (!mem_wait) begin
               next_state = RUN;
            end else if (wait_cnt == WAIT_LAST) begin
               next_state = ERROR;
            end
         end
         ERROR:   next_state = ERROR;
         default: next_state = RUN;
      endcase
   end

   // Output logic. Freeze fires on the first not-ready cycle while still in
   // RUN; a branch seen under freeze is acted on (and counted) only once the
   // freeze lifts. A taken branch outranks load-use: the ID instruction is
   // wrong-path, so stalling it would be wasted.
   always_comb begin
      stall_IF     = 1'b0;
      bubble_ID_EX = 1'b0;
      flush_IF_ID  = 1'b0;
      freeze       = 1'b0;
      memTimeout   = (state == ERROR);
      if ((state == ERROR) || mem_wait) begin
         freeze = 1'b1;
      end else if (branchTaken_EX) begin
         flush_IF_ID  = 1'b1;
         bubble_ID_EX = 1'b1;
      end else if (load_use) begin
         stall_IF     = 1'b1;
         bubble_ID_EX = 1'b1;
      end
   end

   assign stall_inc = freeze || (stall_IF && !flush_IF_ID);

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rstN  (rstN),
      .inc   (stall_inc),
      .count (stallCount)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rstN  (rstN),
      .inc   (flush_IF_ID),
      .count (flushCount)
   );

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
// Self-checking bench: a vector table plus hand-written multi-cycle sequences.
// Every driven cycle pushes its expected outputs to a queue; a negedge
// monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 4;
   localparam int CMAX        = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rstN = 1'b0;
   logic [4:0]       rs1_ID, rs2_ID, rd_EX;
   logic             usesRs1_ID, usesRs2_ID, memRead_EX, branchTaken_EX;
   logic             memReq_MEM, memReady_MEM;
   logic             stall_IF, bubble_ID_EX, flush_IF_ID, freeze, memTimeout;
   logic [CNT_W-1:0] stallCount, flushCount;

   hazard_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rstN           (rstN),
      .rs1_ID         (rs1_ID),
      .rs2_ID         (rs2_ID),
      .usesRs1_ID     (usesRs1_ID),
      .usesRs2_ID     (usesRs2_ID),
      .rd_EX          (rd_EX),
      .memRead_EX     (memRead_EX),
      .branchTaken_EX (branchTaken_EX),
      .memReq_MEM     (memReq_MEM),
      .memReady_MEM   (memReady_MEM),
      .stall_IF       (stall_IF),
      .bubble_ID_EX   (bubble_ID_EX),
      .flush_IF_ID    (flush_IF_ID),
      .freeze         (freeze),
      .memTimeout     (memTimeout),
      .stallCount     (stallCount),
      .flushCount     (flushCount)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       mr;
      logic       bt;
      logic       req;
      logic       rdy;
      logic       st;
      logic       bb;
      logic       fl;
      logic       fz;
      logic       to;
   } vec_t;

   typedef struct packed {
      logic             st;
      logic             bb;
      logic             fl;
      logic             fz;
      logic             to;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
      int               tag;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   m_sc     = 0;
   int   m_fc     = 0;
   int   tag_n    = 0;
   vec_t tbl[15];
   vec_t idle_v;

   function automatic vec_t mk(input int rs1, input int rs2, input bit u1,
                               input bit u2, input int rd, input bit mr,
                               input bit bt, input bit req, input bit rdy,
                               input bit st, input bit bb, input bit fl,
                               input bit fz, input bit to);
      vec_t v;
      v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2; v.rd = 5'(rd);
      v.mr = mr; v.bt = bt; v.req = req; v.rdy = rdy;
      v.st = st; v.bb = bb; v.fl = fl; v.fz = fz; v.to = to;
      return v;
   endfunction

   task automatic chk(input int tag, input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s (vector %0d): actual=%0d required=%0d", nm, tag, act, exp);
      end
   endtask

   // One cycle of stimulus: inputs change just after the edge, the
   // expectation (including counter values from edges so far) is queued,
   // then the counter model is advanced for the coming edge.
   task automatic drive(input vec_t v);
      exp_t e;
      @(posedge clk);
      #1;
      rs1_ID = v.rs1; rs2_ID = v.rs2; usesRs1_ID = v.u1; usesRs2_ID = v.u2;
      rd_EX = v.rd; memRead_EX = v.mr; branchTaken_EX = v.bt;
      memReq_MEM = v.req; memReady_MEM = v.rdy;
      e.st = v.st; e.bb = v.bb; e.fl = v.fl; e.fz = v.fz; e.to = v.to;
      e.sc = CNT_W'(m_sc); e.fc = CNT_W'(m_fc); e.tag = tag_n;
      q.push_back(e);
      tag_n++;
      if (rstN) begin
         if ((v.fz || (v.st && !v.fl)) && m_sc < CMAX) m_sc++;
         if (v.fl && m_fc < CMAX) m_fc++;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rstN = 1'b0;
      m_sc = 0;
      m_fc = 0;
      drive(idle_v);
      @(negedge clk);
      #1;
      rstN = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk(e.tag, "stall_IF", int'(stall_IF), int'(e.st));
         chk(e.tag, "bubble_ID_EX", int'(bubble_ID_EX), int'(e.bb));
         chk(e.tag, "flush_IF_ID", int'(flush_IF_ID), int'(e.fl));
         chk(e.tag, "freeze", int'(freeze), int'(e.fz));
         chk(e.tag, "memTimeout", int'(memTimeout), int'(e.to));
         chk(e.tag, "stallCount", int'(stallCount), int'(e.sc));
         chk(e.tag, "flushCount", int'(flushCount), int'(e.fc));
      end
   end

   initial begin
      idle_v = '0;
      rs1_ID = '0; rs2_ID = '0; rd_EX = '0; usesRs1_ID = 1'b0; usesRs2_ID = 1'b0;
      memRead_EX = 1'b0; branchTaken_EX = 1'b0; memReq_MEM = 1'b0; memReady_MEM = 1'b0;

      //         rs1 rs2 u1 u2 rd mr bt rq ry  st bb fl fz to
      tbl[0]  = mk(0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      tbl[1]  = mk(5,  0, 1, 0, 5, 1, 0, 0, 0,  1, 1, 0, 0, 0); // load-use rs1
      tbl[2]  = mk(0,  0, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0); // rd = x0
      tbl[3]  = mk(0,  7, 0, 0, 7, 1, 0, 0, 0,  0, 0, 0, 0, 0); // rs2 unused
      tbl[4]  = mk(0,  7, 0, 1, 7, 1, 0, 0, 0,  1, 1, 0, 0, 0); // load-use rs2
      tbl[5]  = mk(5,  0, 1, 0, 5, 0, 0, 0, 0,  0, 0, 0, 0, 0); // not a load
      tbl[6]  = mk(3,  0, 1, 0, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0); // no match
      tbl[7]  = mk(5,  0, 1, 0, 5, 1, 1, 0, 0,  0, 1, 1, 0, 0); // branch beats load-use
      tbl[8]  = mk(0,  0, 0, 0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0); // branch alone
      tbl[9]  = mk(5,  0, 1, 0, 5, 1, 0, 0, 1,  1, 1, 0, 0, 0); // ready w/o request
      tbl[10] = mk(5,  0, 1, 0, 5, 1, 0, 1, 1,  1, 1, 0, 0, 0); // request completes
      tbl[11] = mk(5,  0, 1, 0, 5, 1, 1, 1, 0,  0, 0, 0, 1, 0); // freeze beats all
      tbl[12] = mk(0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // wait dropped
      tbl[13] = mk(9,  4, 0, 1, 9, 1, 0, 0, 0,  0, 0, 0, 0, 0); // rs1 match unused
      tbl[14] = mk(31, 4, 1, 1, 31,1, 0, 0, 0,  1, 1, 0, 0, 0); // rd = x31

      do_reset();
      for (int i = 0; i < 15; i++) drive(tbl[i]);

      // Branch and load-use in the same cycle.
      do_reset();
      drive(mk(5, 0, 1, 0, 5, 1, 1, 0, 0,  0, 1, 1, 0, 0));
      drive(idle_v);
      @(negedge clk);
      chk(-1, "flushCount_after_branch", int'(flushCount), 1);
      chk(-1, "stallCount_after_branch", int'(stallCount), 0);

      // Three not-ready cycles, then ready; FSM must be back in RUN.
      do_reset();
      repeat (3) drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0));
      drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0));
      @(negedge clk);
      chk(-2, "stallCount_after_wait", int'(stallCount), 3);
      drive(mk(5, 0, 1, 0, 5, 1, 0, 0, 0,  1, 1, 0, 0, 0));

      // Branch held under freeze: counted once, when freeze lifts.
      do_reset();
      drive(mk(0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 0));
      drive(mk(0, 0, 0, 0, 0, 0, 1, 1, 1,  0, 1, 1, 0, 0));
      drive(idle_v);
      @(negedge clk);
      chk(-3, "flushCount_held_branch", int'(flushCount), 1);

      // Timeout: one RUN cycle plus MEM_TIMEOUT MEM_WAIT cycles, then ERROR.
      do_reset();
      repeat (1 + MEM_TIMEOUT) drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0));
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1));
      drive(mk(5, 0, 1, 0, 5, 1, 1, 0, 0,  0, 0, 0, 1, 1));
      do_reset();
      drive(mk(5, 0, 1, 0, 5, 1, 0, 0, 0,  1, 1, 0, 0, 0));

      // Saturation: 20 stall cycles on a 4-bit counter.
      do_reset();
      repeat (20) drive(mk(5, 0, 1, 0, 5, 1, 0, 0, 0,  1, 1, 0, 0, 0));
      drive(idle_v);
      @(negedge clk);
      chk(-4, "stallCount_saturated", int'(stallCount), 15);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
